// File: rtl/micro_pipe.sv
// micro_pipe: 5-stage IF/ID/EX/MEM/WB pipeline for a small MIPS-like ISA
// (add, sub, and, or, slt, addi, lw, sw, beq, bne, j, jr, HALT).
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   imem_we/addr/wdata - instruction memory load port (word addressed)
//   dbg_raddr/rdata   - combinational register-file debug read
//   halted            - set once HALT reaches WB, held until reset
//   pc_out            - current fetch PC
//   cycle_cnt, retire_cnt, stall_cnt - 32-bit wrapping performance counters
module micro_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata,
  output logic                          halted,
  output logic [XLEN-1:0]               pc_out,
  output logic [31:0]                   cycle_cnt,
  output logic [31:0]                   retire_cnt,
  output logic [31:0]                   stall_cnt
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2b, OpHalt = 6'h3f;
  localparam logic [5:0] FnJr = 6'h08, FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24;
  localparam logic [5:0] FnOr = 6'h25, FnSlt = 6'h2a;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            alu_imm;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            beq;
    logic            bne;
    logic            jr;
    logic            halt;
  } idex_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] st_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            halt;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            reg_write;
  } memwb_t;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] rf_q [32];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  idex_t           idex_q, idex_d;
  exmem_t          exmem_q, exmem_d;
  memwb_t          memwb_q, memwb_d;
  logic            fetch_stop_q, fetch_stop_d;
  logic            halted_q;
  logic [31:0]     cycle_q, retire_q, stall_q;

  // Instruction memory: synchronous load port, combinational fetch.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc4;
  assign if_instr = imem[pc_q[IAW+1:2]];
  assign if_pc4   = pc_q + XLEN'(4);

  // ---------------- ID ----------------
  logic [5:0]      id_op, id_fn;
  logic [4:0]      id_rs, id_rt, id_rd, id_dst;
  logic [XLEN-1:0] id_imm, id_rs_val, id_rt_val, j_target;
  logic            id_reg_write, id_alu_imm, id_mem_read, id_mem_write;
  logic            id_beq, id_bne, id_jr, id_j, id_halt;
  alu_op_e         id_alu_op;
  logic            wb_we;

  assign id_op  = ifid_instr_q[31:26];
  assign id_rs  = ifid_instr_q[25:21];
  assign id_rt  = ifid_instr_q[20:16];
  assign id_rd  = ifid_instr_q[15:11];
  assign id_fn  = ifid_instr_q[5:0];
  assign id_imm = XLEN'(signed'(ifid_instr_q[15:0]));

  if (XLEN > 28) begin : g_jwide
    assign j_target = {ifid_pc4_q[XLEN-1:28], ifid_instr_q[25:0], 2'b00};
  end else begin : g_jnarrow
    assign j_target = XLEN'({ifid_instr_q[25:0], 2'b00});
  end

  always_comb begin
    id_reg_write = 1'b0;
    id_alu_imm   = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    id_beq       = 1'b0;
    id_bne       = 1'b0;
    id_jr        = 1'b0;
    id_j         = 1'b0;
    id_halt      = 1'b0;
    id_alu_op    = AluAdd;
    id_dst       = id_rd;
    case (id_op)
      OpRtype: begin
        id_reg_write = 1'b1;
        case (id_fn)
          FnAdd:   id_alu_op = AluAdd;
          FnSub:   id_alu_op = AluSub;
          FnAnd:   id_alu_op = AluAnd;
          FnOr:    id_alu_op = AluOr;
          FnSlt:   id_alu_op = AluSlt;
          FnJr:    begin id_jr = 1'b1; id_reg_write = 1'b0; end
          default: id_reg_write = 1'b0;
        endcase
      end
      OpAddi:  begin id_reg_write = 1'b1; id_alu_imm = 1'b1; id_dst = id_rt; end
      OpLw:    begin
        id_reg_write = 1'b1; id_alu_imm = 1'b1; id_mem_read = 1'b1; id_dst = id_rt;
      end
      OpSw:    begin id_mem_write = 1'b1; id_alu_imm = 1'b1; end
      OpBeq:   id_beq = 1'b1;
      OpBne:   id_bne = 1'b1;
      OpJ:     id_j = 1'b1;
      OpHalt:  id_halt = 1'b1;
      default: ;
    endcase
  end

  // Register read with same-cycle WB bypass; r0 is never written.
  assign wb_we     = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != 5'd0);
  assign id_rs_val = (wb_we && memwb_q.rd == id_rs) ? memwb_q.wdata : rf_q[id_rs];
  assign id_rt_val = (wb_we && memwb_q.rd == id_rt) ? memwb_q.wdata : rf_q[id_rt];

  // ---------------- EX ----------------
  logic            mem_fwd_ok;
  logic [XLEN-1:0] ex_a, ex_b, ex_alu_b, ex_res, ex_target;
  logic            ex_taken;

  assign mem_fwd_ok = exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != 5'd0);

  always_comb begin
    ex_a = idex_q.rs_val;
    if (mem_fwd_ok && exmem_q.rd == idex_q.rs)  ex_a = exmem_q.alu_res;
    else if (wb_we && memwb_q.rd == idex_q.rs)  ex_a = memwb_q.wdata;
    ex_b = idex_q.rt_val;
    if (mem_fwd_ok && exmem_q.rd == idex_q.rt)  ex_b = exmem_q.alu_res;
    else if (wb_we && memwb_q.rd == idex_q.rt)  ex_b = memwb_q.wdata;
  end

  assign ex_alu_b = idex_q.alu_imm ? idex_q.imm : ex_b;

  always_comb begin
    ex_res = '0;
    case (idex_q.alu_op)
      AluAdd:  ex_res = ex_a + ex_alu_b;
      AluSub:  ex_res = ex_a - ex_alu_b;
      AluAnd:  ex_res = ex_a & ex_alu_b;
      AluOr:   ex_res = ex_a | ex_alu_b;
      AluSlt:  ex_res = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_alu_b)};
      default: ex_res = '0;
    endcase
  end

  assign ex_taken  = idex_q.valid && ((idex_q.beq && ex_a == ex_b) ||
                                      (idex_q.bne && ex_a != ex_b) || idex_q.jr);
  assign ex_target = idex_q.jr ? ex_a : idex_q.pc4 + (idex_q.imm << 2);

  // ---------------- hazards / fetch control ----------------
  logic load_use, stall, id_live, halt_dec, j_dec;

  assign load_use = idex_q.valid && idex_q.mem_read && ifid_valid_q &&
                    (idex_q.rt == id_rs || idex_q.rt == id_rt);
  // An EX redirect overrides both a load-use stall and an ID jump/HALT.
  assign stall    = load_use && !ex_taken;
  assign id_live  = ifid_valid_q && !ex_taken && !stall;
  assign halt_dec = id_live && id_halt;
  assign j_dec    = id_live && id_j;

  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = 1'b0;
    ifid_instr_d = if_instr;
    ifid_pc4_d   = if_pc4;
    if (ex_taken) begin
      pc_d = ex_target;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
    end else if (fetch_stop_q || halt_dec) begin
      pc_d = pc_q;
    end else if (j_dec) begin
      pc_d = j_target;
    end else begin
      pc_d         = if_pc4;
      ifid_valid_d = 1'b1;
    end
  end

  assign fetch_stop_d = fetch_stop_q || halt_dec;

  always_comb begin
    idex_d = '0;
    if (id_live) begin
      idex_d.valid     = 1'b1;
      idex_d.pc4       = ifid_pc4_q;
      idex_d.rs_val    = id_rs_val;
      idex_d.rt_val    = id_rt_val;
      idex_d.rs        = id_rs;
      idex_d.rt        = id_rt;
      idex_d.rd        = id_dst;
      idex_d.imm       = id_imm;
      idex_d.alu_op    = id_alu_op;
      idex_d.alu_imm   = id_alu_imm;
      idex_d.mem_read  = id_mem_read;
      idex_d.mem_write = id_mem_write;
      idex_d.reg_write = id_reg_write;
      idex_d.beq       = id_beq;
      idex_d.bne       = id_bne;
      idex_d.jr        = id_jr;
      idex_d.halt      = id_halt;
    end
  end

  always_comb begin
    exmem_d = '0;
    if (idex_q.valid) begin
      exmem_d.valid     = 1'b1;
      exmem_d.alu_res   = ex_res;
      exmem_d.st_data   = ex_b;
      exmem_d.rd        = idex_q.rd;
      exmem_d.reg_write = idex_q.reg_write;
      exmem_d.mem_read  = idex_q.mem_read;
      exmem_d.mem_write = idex_q.mem_write;
      exmem_d.halt      = idex_q.halt;
    end
  end

  // ---------------- MEM ----------------
  logic [DAW-1:0]  dmem_idx;
  logic [XLEN-1:0] dmem_rdata;
  assign dmem_idx   = exmem_q.alu_res[DAW+1:2];
  assign dmem_rdata = dmem[dmem_idx];

  // exmem_q is cleared asynchronously, so no store survives a reset edge.
  always_ff @(posedge clk) begin
    if (exmem_q.valid && exmem_q.mem_write) dmem[dmem_idx] <= exmem_q.st_data;
  end

  always_comb begin
    memwb_d = '0;
    if (exmem_q.valid) begin
      memwb_d.valid     = 1'b1;
      memwb_d.wdata     = exmem_q.mem_read ? dmem_rdata : exmem_q.alu_res;
      memwb_d.rd        = exmem_q.rd;
      memwb_d.reg_write = exmem_q.reg_write;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[memwb_q.rd] <= memwb_q.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
      fetch_stop_q <= 1'b0;
      halted_q     <= 1'b0;
      cycle_q      <= '0;
      retire_q     <= '0;
      stall_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
      fetch_stop_q <= fetch_stop_d;
      // Rises on the edge HALT enters MEM/WB, i.e. while HALT sits in WB.
      halted_q     <= halted_q || (exmem_q.valid && exmem_q.halt);
      if (!halted_q)     cycle_q  <= cycle_q + 32'd1;
      if (memwb_q.valid) retire_q <= retire_q + 32'd1;
      if (stall)         stall_q  <= stall_q + 32'd1;
    end
  end

  assign dbg_rdata  = rf_q[dbg_raddr];
  assign halted     = halted_q;
  assign pc_out     = pc_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_micro_pipe.sv
// Bench for micro_pipe: a 32-bit and a 16-bit instance. Each test loads a
// small program, pushes expected register values to a scoreboard queue, runs
// until HALT retires, then pops and compares against the debug read port.
module tb_micro_pipe;

  localparam logic [5:0] OpJ = 6'h02, OpBne = 6'h05, OpAddi = 6'h08;
  localparam logic [5:0] OpLw = 6'h23, OpSw = 6'h2b;
  localparam logic [5:0] FnJr = 6'h08, FnAdd = 6'h20, FnSub = 6'h22, FnSlt = 6'h2a;
  localparam logic [31:0] Halt = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we32 = 1'b0, we16 = 1'b0;
  logic [7:0]  addr32 = '0, addr16 = '0;
  logic [31:0] wdata32 = '0, wdata16 = '0;
  logic [4:0]  raddr32 = '0, raddr16 = '0;
  logic [31:0] rdata32, pc32, cyc32, ret32, stl32, cyc16, ret16, stl16;
  logic [15:0] rdata16, pc16;
  logic        halted32, halted16;

  always #5 clk = ~clk;

  micro_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .imem_we(we32), .imem_addr(addr32), .imem_wdata(wdata32),
    .dbg_raddr(raddr32), .dbg_rdata(rdata32), .halted(halted32), .pc_out(pc32),
    .cycle_cnt(cyc32), .retire_cnt(ret32), .stall_cnt(stl32)
  );

  micro_pipe #(.XLEN(16)) u_dut16 (
    .clk(clk), .reset(reset), .imem_we(we16), .imem_addr(addr16), .imem_wdata(wdata16),
    .dbg_raddr(raddr16), .dbg_rdata(rdata16), .halted(halted16), .pc_out(pc16),
    .cycle_cnt(cyc16), .retire_cnt(ret16), .stall_cnt(stl16)
  );

  typedef struct {
    int          r;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input int r, input logic [31:0] v);
    exp_t e;
    e.r = r;
    e.v = v;
    return e;
  endfunction

  // Holds reset, writes 32 words (program then zero NOPs), releases reset.
  task automatic load_prog(input bit narrow);
    logic [31:0] w;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w = (i < prog.size()) ? prog[i] : 32'h0;
      if (narrow) begin we16 = 1'b1; addr16 = 8'(i); wdata16 = w; end
      else        begin we32 = 1'b1; addr32 = 8'(i); wdata32 = w; end
    end
    @(negedge clk);
    we16 = 1'b0;
    we32 = 1'b0;
    prog.delete();
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input bit narrow, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if ((narrow ? halted16 : halted32) === 1'b1) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic peek(input bit narrow, input int r, output logic [31:0] v);
    if (narrow) raddr16 = 5'(r);
    else        raddr32 = 5'(r);
    #1;
    v = narrow ? {16'h0, rdata16} : rdata32;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (halted32 !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted32); end
    n_tests++; if (pc32 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc32); end
    n_tests++; if (cyc32 !== 32'h0 || ret32 !== 32'h0 || stl32 !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters got %h %h %h want 0 0 0", cyc32, ret32, stl32);
    end
    n_tests++; if (halted16 !== 1'b0 || pc16 !== 16'h0) begin
      n_fail++; $display("FAIL reset_16 got halted=%b pc=%h want 0 0", halted16, pc16);
    end
  endtask

  task automatic test_forwarding();
    bit ok; exp_t e; logic [31:0] v;
    prog = '{itype(OpAddi, 0, 1, 16'd5), rtype(1, 1, 2, FnAdd), rtype(2, 1, 3, FnSub), Halt};
    sb.push_back(mk(1, 32'd5)); sb.push_back(mk(2, 32'd10)); sb.push_back(mk(3, 32'd5));
    load_prog(1'b0);
    run_until_halt(1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fwd_halt_timeout got 0 want 1"); end
    n_tests++; if (stl32 !== 32'd0) begin n_fail++; $display("FAIL fwd_stall got %0d want 0", stl32); end
    n_tests++; if (ret32 !== 32'd4) begin n_fail++; $display("FAIL fwd_retire got %0d want 4", ret32); end
    n_tests++; if (cyc32 !== 32'd7) begin n_fail++; $display("FAIL fwd_cycles got %0d want 7", cyc32); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); peek(1'b0, e.r, v); n_tests++;
      if (v !== e.v) begin n_fail++; $display("FAIL fwd_r%0d got %h want %h", e.r, v, e.v); end
    end
  endtask

  task automatic test_load_use();
    bit ok; exp_t e; logic [31:0] v;
    prog = '{itype(OpAddi, 0, 1, 16'd7), itype(OpSw, 0, 1, 16'd0), itype(OpLw, 0, 4, 16'd0),
             rtype(4, 4, 5, FnAdd), Halt};
    sb.push_back(mk(4, 32'd7)); sb.push_back(mk(5, 32'd14));
    load_prog(1'b0);
    run_until_halt(1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL lu_halt_timeout got 0 want 1"); end
    n_tests++; if (stl32 !== 32'd1) begin n_fail++; $display("FAIL lu_stall got %0d want 1", stl32); end
    n_tests++; if (ret32 !== 32'd5) begin n_fail++; $display("FAIL lu_retire got %0d want 5", ret32); end
    n_tests++; if (cyc32 !== 32'd9) begin n_fail++; $display("FAIL lu_cycles got %0d want 9", cyc32); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); peek(1'b0, e.r, v); n_tests++;
      if (v !== e.v) begin n_fail++; $display("FAIL lu_r%0d got %h want %h", e.r, v, e.v); end
    end
  endtask

  task automatic test_branch_flush();
    bit ok; exp_t e; logic [31:0] v;
    prog = '{itype(OpAddi, 0, 0, 16'd5), rtype(0, 0, 13, FnAdd), itype(OpAddi, 0, 1, 16'd1),
             itype(OpBne, 1, 0, 16'd2), itype(OpAddi, 0, 6, 16'd9), itype(OpAddi, 0, 7, 16'd9),
             itype(OpAddi, 0, 8, 16'd3), Halt};
    sb.push_back(mk(0, 32'd0)); sb.push_back(mk(13, 32'd0)); sb.push_back(mk(1, 32'd1));
    sb.push_back(mk(6, 32'd0)); sb.push_back(mk(7, 32'd0)); sb.push_back(mk(8, 32'd3));
    load_prog(1'b0);
    run_until_halt(1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL br_halt_timeout got 0 want 1"); end
    n_tests++; if (ret32 !== 32'd6) begin n_fail++; $display("FAIL br_retire got %0d want 6", ret32); end
    n_tests++; if (stl32 !== 32'd0) begin n_fail++; $display("FAIL br_stall got %0d want 0", stl32); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); peek(1'b0, e.r, v); n_tests++;
      if (v !== e.v) begin n_fail++; $display("FAIL br_r%0d got %h want %h", e.r, v, e.v); end
    end
  endtask

  task automatic test_jump_jr();
    bit ok; exp_t e; logic [31:0] v;
    for (int i = 0; i < 17; i++) prog.push_back(32'h0);
    prog[0]  = {OpJ, 26'h8};
    prog[1]  = itype(OpAddi, 0, 10, 16'd1);
    prog[8]  = itype(OpAddi, 0, 9, 16'h40);
    prog[9]  = rtype(9, 0, 0, FnJr);
    prog[10] = itype(OpAddi, 0, 11, 16'd1);
    prog[11] = itype(OpAddi, 0, 12, 16'd1);
    prog[16] = Halt;
    sb.push_back(mk(9, 32'h40)); sb.push_back(mk(10, 32'd0));
    sb.push_back(mk(11, 32'd0)); sb.push_back(mk(12, 32'd0));
    load_prog(1'b0);
    run_until_halt(1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL j_halt_timeout got 0 want 1"); end
    n_tests++; if (ret32 !== 32'd4) begin n_fail++; $display("FAIL j_retire got %0d want 4", ret32); end
    n_tests++; if (cyc32 !== 32'd10) begin n_fail++; $display("FAIL j_cycles got %0d want 10", cyc32); end
    n_tests++; if (pc32 !== 32'h44) begin n_fail++; $display("FAIL j_pc got %h want 44", pc32); end
    repeat (3) @(negedge clk);
    n_tests++; if (pc32 !== 32'h44 || halted32 !== 1'b1) begin
      n_fail++; $display("FAIL j_frozen got pc=%h halted=%b want 44 1", pc32, halted32);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); peek(1'b0, e.r, v); n_tests++;
      if (v !== e.v) begin n_fail++; $display("FAIL j_r%0d got %h want %h", e.r, v, e.v); end
    end
  endtask

  task automatic test_xlen16();
    bit ok; exp_t e; logic [31:0] v;
    prog = '{itype(OpAddi, 0, 1, 16'h7FFF), itype(OpAddi, 1, 1, 16'd1), rtype(1, 0, 2, FnSlt),
             itype(OpAddi, 0, 3, 16'hFFFF), rtype(1, 3, 4, FnAdd), Halt};
    sb.push_back(mk(1, 32'h8000)); sb.push_back(mk(2, 32'h1));
    sb.push_back(mk(3, 32'hFFFF)); sb.push_back(mk(4, 32'h7FFF));
    load_prog(1'b1);
    run_until_halt(1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL x16_halt_timeout got 0 want 1"); end
    n_tests++; if (ret16 !== 32'd6) begin n_fail++; $display("FAIL x16_retire got %0d want 6", ret16); end
    n_tests++; if (cyc16 !== 32'd9) begin n_fail++; $display("FAIL x16_cycles got %0d want 9", cyc16); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); peek(1'b1, e.r, v); n_tests++;
      if (v !== e.v) begin n_fail++; $display("FAIL x16_r%0d got %h want %h", e.r, v, e.v); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    prog = '{itype(OpAddi, 0, 1, 16'd5), itype(OpSw, 0, 1, 16'd0), itype(OpAddi, 2, 2, 16'd1),
             {OpJ, 26'h1}};
    load_prog(1'b0);
    repeat (30) @(negedge clk);
    peek(1'b0, 2, v);
    n_tests++; if (v === 32'd0) begin n_fail++; $display("FAIL rst_loop_progress got %h want nonzero", v); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (cyc32 !== 0 || ret32 !== 0 || stl32 !== 0 || halted32 !== 1'b0 || pc32 !== 0) begin
      n_fail++;
      $display("FAIL rst_state got cyc=%h ret=%h stl=%h halted=%b pc=%h want all 0",
               cyc32, ret32, stl32, halted32, pc32);
    end
    peek(1'b0, 1, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_r1 got %h want 0", v); end
    peek(1'b0, 2, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_r2 got %h want 0", v); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (pc32 !== 32'h4) begin n_fail++; $display("FAIL rst_first_fetch got %h want 4", pc32); end
    repeat (5) @(negedge clk);
    peek(1'b0, 1, v);
    n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL rst_restart_r1 got %h want 5", v); end
    n_tests++; if (cyc32 !== 32'd6) begin n_fail++; $display("FAIL rst_restart_cycles got %0d want 6", cyc32); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_jump_jr();
    test_xlen16();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
